inst_sram_resp: RTL and testbench
=================================

// Module: inst_sram_resp
// PURPOSE
//  Responder side of the inst_sram interface driven by the fetch stage: en/we/addr/wdata in, rdata out.
//  Holds a DEPTH-word synchronous instruction RAM mapped at BASE_ADDR, with 1-cycle read latency.
//  Provides a streaming preload port (valid/ready) used by the boot loader / bench to fill the RAM.
//  Flags out-of-range CPU accesses on a registered error output.
// PARAMETERS
//  DEPTH      1024          number of 32-bit words; power of two >= 4
//  BASE_ADDR  32'h1c00_0000 byte address of word 0 (first fetch after reset)
//  OOR_DATA   32'h0340_0000 rdata returned for out-of-range reads (NOP encoding)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  resetn          in   1   asynchronous, active-low reset
//  inst_sram_en    in   1   access request this cycle
//  inst_sram_we    in   4   byte write enables; 4'h0 = read
//  inst_sram_addr  in   32  byte address; bits [1:0] ignored
//  inst_sram_wdata in   32  write data
//  inst_sram_rdata out  32  read data, valid the cycle after a read request
//  inst_sram_err   out  1   1-cycle pulse: access the previous cycle was out of range
//  load_start      in   1   pulse: restart preload at word 0
//  load_valid      in   1   preload word available
//  load_data       in   32  preload word
//  load_ready      out  1   preload word accepted this cycle when load_valid & load_ready
//  load_done       out  1   high once DEPTH words have been loaded, until next load_start
// BEHAVIOUR
//  Reset (resetn=0, async): rdata=0, err=0, load FSM=IDLE, load_ready=0, load_done=0, load_cnt=0.
//   RAM contents are not reset. Reset mid-preload aborts; a new load_start is required.
//  Decode: off = addr[31:2]-BASE_ADDR[31:2] (30-bit, wraps); in_range = off < DEPTH; idx = off[AW-1:0].
//  Read (en & we==0): in range -> rdata <= mem[idx] next edge; out of range -> rdata <= OOR_DATA, err <= 1.
//  Write (en & we!=0): in range -> byte lanes with we[i]=1 updated at edge; out of range -> no write, err <= 1.
//   rdata after a write cycle holds its previous value.
//  en=0: rdata holds last value indefinitely; err <= 0. err is 0 every cycle not following an OOR access.
//  Load FSM: IDLE -(load_start)-> LOADING -(accept with load_cnt==DEPTH-1)-> DONE -(load_start)-> LOADING.
//   load_start in any state clears load_cnt to 0, clears load_done, enters LOADING (same edge; no accept that cycle).
//   load_ready = (state==LOADING) & ~inst_sram_en & ~load_start  (CPU port always wins the RAM).
//   accept: mem[load_cnt] <= load_data (all 4 lanes); load_cnt <= load_cnt+1.
//   DONE: load_done=1, load_ready=0; load_cnt holds DEPTH-1 (no wrap).
//  CPU accesses during LOADING are legal and serviced normally; preload simply stalls.
//  Read-during-write same address, same cycle on CPU port is impossible (single port); preload write
//   never coincides with a CPU access by the arbitration rule above.
// CONFIGURATION
//  INST_SRAM_WFWD_EN defined: if a CPU read hits the word written by a CPU write or preload accept
//   in the immediately preceding cycle, rdata is forwarded from a 1-entry write buffer (idx, data, we)
//   so the new bytes are returned; identical result to the plain RAM, but the RAM macro may be
//   write-first or read-first. One extra 32+AW+4-bit register.
//  Not defined: no buffer; RAM must be inferred as a plain synchronous array (behaviour as above).
// TESTING
//  Reset: drive resetn=0 mid-cycle -> rdata=0, err=0, load_ready=0, load_done=0 immediately.
//  Preload: load_start, stream DEPTH words w[i]=32'hA5000000+i with load_valid=1 -> load_done after
//   DEPTH accepts; read 0x1c000000 -> 32'hA5000000, read 0x1c000000+4*(DEPTH-1) -> A5000000+DEPTH-1.
//  Arbitration: load_valid=1 with inst_sram_en=1 for 3 cycles -> load_ready=0, load_cnt unchanged.
//  Byte write: write we=4'b0101 wdata=32'h11223344 to 0x1c000010 over 32'hFFFFFFFF, read -> 32'hFF22FF44.
//  Out of range: read 0x1bfffffc -> rdata=32'h03400000, err pulses one cycle; write 0x1c000000+4*DEPTH
//   -> err=1, RAM word 0 unchanged.
//  Back-to-back: write 32'hDEADBEEF to idx 5 then read idx 5 next cycle -> rdata=32'hDEADBEEF (both builds).

Source files
------------

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: DEPTH-word synchronous RAM at BASE_ADDR with a streaming preload port.
// Define INST_SRAM_WFWD_EN to add a 1-entry write buffer that forwards last-cycle writes to reads.
module inst_sram_resp #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter logic [31:0] OOR_DATA  = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_err,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_done
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOADING = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] load_cnt;

    logic [29:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          cpu_rd;
    logic          cpu_wr;
    logic          load_accept;
    logic          unused_addr_lsb;

    // The offset subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign off             = inst_sram_addr[31:2] - BASE_ADDR[31:2];
    assign in_range        = off < 30'(DEPTH);
    assign idx             = off[AW-1:0];
    assign cpu_rd          = inst_sram_en & (inst_sram_we == 4'h0);
    assign cpu_wr          = inst_sram_en & (inst_sram_we != 4'h0);
    assign unused_addr_lsb = ^inst_sram_addr[1:0];

    assign load_ready  = (state == S_LOADING) & ~inst_sram_en & ~load_start;
    assign load_accept = load_valid & load_ready;
    assign load_done   = (state == S_DONE);

    // Single RAM write port shared by the CPU and the preload stream.
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = inst_sram_we;
        wr_data = inst_sram_wdata;
        if (cpu_wr && in_range) begin
            wr_en = 1'b1;
        end else if (load_accept) begin
            wr_en   = 1'b1;
            wr_idx  = load_cnt;
            wr_be   = 4'hF;
            wr_data = load_data;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto a memory macro; contents are undefined until loaded.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    logic [31:0] rd_word;

`ifdef INST_SRAM_WFWD_EN
    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [3:0]    wb_be;
    logic [31:0]   wb_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_be    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wr_en;
            wb_idx   <= wr_idx;
            wb_be    <= wr_be;
            wb_data  <= wr_data;
        end
    end

    // Overlay last cycle's written lanes so a read-first macro still returns the new bytes.
    always_comb begin
        rd_word = mem[idx];
        if (wb_valid && (wb_idx == idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_be[i]) rd_word[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
    end
`else
    assign rd_word = mem[idx];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= '0;
            inst_sram_err   <= 1'b0;
        end else begin
            inst_sram_err <= inst_sram_en & ~in_range;
            if (cpu_rd) inst_sram_rdata <= in_range ? rd_word : OOR_DATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            load_cnt <= '0;
        end else if (load_start) begin
            state    <= S_LOADING;
            load_cnt <= '0;
        end else if (load_accept) begin
            if (load_cnt == AW'(DEPTH - 1)) state <= S_DONE;
            else                            load_cnt <= load_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: reset, preload, arbitration, byte writes, out-of-range, back-to-back.
module tb_inst_sram_resp;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam logic [31:0] OOR   = 32'h0340_0000;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_err;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    int errors = 0;
    int checks = 0;

    inst_sram_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .OOR_DATA(OOR)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .inst_sram_err  (inst_sram_err),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_done      (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (in_rng(a)) return model[(a - BASE) >> 2];
        return OOR;
    endfunction

    // Drive one CPU cycle at the falling edge; return just after the next rising edge.
    task automatic cpu_access(input logic en, input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        @(negedge clk);
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        exp_q.push_back(exp_read(addr));
        cpu_access(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        if (in_rng(addr)) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) model[(addr - BASE) >> 2][8*i +: 8] = data[8*i +: 8];
        end
        cpu_access(1'b1, we, addr, data);
    endtask

    task automatic idle();
        cpu_access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (inst_sram_rdata !== 32'h0 || inst_sram_err !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h err=%b ready=%b done=%b, required 0/0/0/0",
                     inst_sram_rdata, inst_sram_err, load_ready, load_done);
        end
        // Load up some non-reset state: an OOR read plus a preload start.
        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_addr = BASE - 4; load_start = 1'b1;
        @(posedge clk); #1;
        inst_sram_en = 1'b0; load_start = 1'b0;
        #1;
        checks++;
        if (inst_sram_rdata !== OOR || inst_sram_err !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: rdata=%h err=%b ready=%b, required %h/1/1",
                     inst_sram_rdata, inst_sram_err, load_ready, OOR);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (inst_sram_rdata !== 32'h0 || inst_sram_err !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdata=%h err=%b ready=%b done=%b, required 0/0/0/0",
                     inst_sram_rdata, inst_sram_err, load_ready, load_done);
        end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_aborts_load: load_ready=%b, required 0", load_ready);
        end
    endtask

    task automatic test_preload();
        int  not_ready = 0;
        logic done_early = 1'b0;
        @(negedge clk) load_start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_start = 1'b0;
            load_valid = 1'b1;
            load_data  = 32'hA500_0000 + 32'(i);
            #1;
            if (load_ready !== 1'b1) not_ready++;
            if (load_done !== 1'b0) done_early = 1'b1;
            @(posedge clk);
            model[i] = 32'hA500_0000 + 32'(i);
        end
        #1;
        checks++;
        if (not_ready != 0 || done_early) begin
            errors++;
            $display("FAIL preload_stream: not_ready_cycles=%0d done_early=%b, required 0/0", not_ready, done_early);
        end
        checks++;
        if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL preload_done: done=%b ready=%b, required 1/0", load_done, load_ready);
        end
        @(negedge clk) load_valid = 1'b0;
        rd(BASE);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || exp !== 32'hA500_0000) begin
            errors++;
            $display("FAIL preload_word0: got %h, required %h", inst_sram_rdata, 32'hA500_0000);
        end
        rd(BASE + 32'(4 * (DEPTH - 1)));
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp) begin
            errors++;
            $display("FAIL preload_last: got %h, required %h", inst_sram_rdata, exp);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] rd_addr [3];
        rd_addr[0] = BASE; rd_addr[1] = BASE + 4; rd_addr[2] = BASE + 400;
        @(negedge clk);
        inst_sram_en = 1'b0; load_start = 1'b1; load_valid = 1'b1; load_data = 32'h5A5A_0000;
        @(posedge clk); #1;
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears_done: done=%b, required 0", load_done);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load_start = 1'b0;
            load_data  = 32'h5A5A_0000 + 32'(i);
            @(posedge clk);
            model[i] = 32'h5A5A_0000 + 32'(i);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_data = 32'h5A5A_00FF;
            inst_sram_en = 1'b1; inst_sram_we = 4'h0; inst_sram_addr = rd_addr[k];
            exp_q.push_back(exp_read(rd_addr[k]));
            #1;
            checks++;
            if (load_ready !== 1'b0) begin
                errors++;
                $display("FAIL arb_ready[%0d]: load_ready=%b, required 0", k, load_ready);
            end
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks++;
            if (inst_sram_rdata !== exp) begin
                errors++;
                $display("FAIL arb_read[%0d]: got %h, required %h", k, inst_sram_rdata, exp);
            end
        end
        @(negedge clk);
        inst_sram_en = 1'b0; load_data = 32'h5A5A_0002;
        @(posedge clk);
        model[2] = 32'h5A5A_0002;
        @(negedge clk) load_valid = 1'b0;
        rd(BASE + 8);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp) begin
            errors++;
            $display("FAIL arb_cnt_held: got %h, required %h", inst_sram_rdata, exp);
        end
        rd(BASE + 12);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp) begin
            errors++;
            $display("FAIL arb_no_stray_write: got %h, required %h", inst_sram_rdata, exp);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] prev;
        rd(BASE + 16);
        prev = exp_q.pop_front();
        wr(BASE + 16, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (inst_sram_rdata !== prev) begin
            errors++;
            $display("FAIL rdata_hold_on_write: got %h, required %h", inst_sram_rdata, prev);
        end
        wr(BASE + 16, 4'b0101, 32'h1122_3344);
        idle();
        rd(BASE + 16);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || exp !== 32'hFF22_FF44) begin
            errors++;
            $display("FAIL byte_write: got %h, required %h", inst_sram_rdata, 32'hFF22_FF44);
        end
    endtask

    task automatic test_out_of_range();
        rd(BASE - 4);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || inst_sram_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read_low: rdata=%h err=%b, required %h/1", inst_sram_rdata, inst_sram_err, exp);
        end
        idle();
        checks++;
        if (inst_sram_rdata !== OOR || inst_sram_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_end: rdata=%h err=%b, required %h/0", inst_sram_rdata, inst_sram_err, OOR);
        end
        wr(BASE + 32'(4 * DEPTH), 4'hF, 32'h1234_5678);
        checks++;
        if (inst_sram_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_err: err=%b, required 1", inst_sram_err);
        end
        rd(BASE);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || inst_sram_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_no_effect: rdata=%h err=%b, required %h/0", inst_sram_rdata, inst_sram_err, exp);
        end
        rd(BASE + 32'(4 * (DEPTH - 1)));
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || inst_sram_err !== 1'b0) begin
            errors++;
            $display("FAIL top_word_in_range: rdata=%h err=%b, required %h/0", inst_sram_rdata, inst_sram_err, exp);
        end
        rd(32'h0000_0000);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || inst_sram_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_wrap_zero: rdata=%h err=%b, required %h/1", inst_sram_rdata, inst_sram_err, exp);
        end
    endtask

    task automatic test_back_to_back();
        wr(BASE + 20, 4'hF, 32'hDEAD_BEEF);
        rd(BASE + 20);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || exp !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_full: got %h, required %h", inst_sram_rdata, 32'hDEAD_BEEF);
        end
        wr(BASE + 20, 4'b1000, 32'h1100_0000);
        rd(BASE + 20);
        exp = exp_q.pop_front();
        checks++;
        if (inst_sram_rdata !== exp || exp !== 32'h11AD_BEEF) begin
            errors++;
            $display("FAIL b2b_partial: got %h, required %h", inst_sram_rdata, 32'h11AD_BEEF);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_arbitration();
        test_byte_write();
        test_out_of_range();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
